// File: rtl/lim_pkg.sv
// rtl/lim_pkg.sv - shared constants and helpers for the limited-modulus chain counter
package lim_pkg;

  localparam int DIGIT_W_DEF = 4;

  // Two minutes-and-seconds style pairs: digit 0 (LSBs) is mod 10, digit 1 is mod 6.
  localparam logic [15:0] LIMITS_DEF = {4'd6, 4'd10, 4'd6, 4'd10};

  function automatic int presc_w(input int p);
    return (p <= 2) ? 1 : $clog2(p);
  endfunction

endpackage

// File: rtl/lim_digit.sv
// rtl/lim_digit.sv - one modulo-LIMIT digit of the cascaded counter
module lim_digit
  import lim_pkg::*;
#(
  parameter int DIGIT_W = DIGIT_W_DEF,
  parameter int LIMIT   = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_d,
  input  logic               step,
  input  logic               dir,
  input  logic               cin,
  output logic [DIGIT_W-1:0] q,
  output logic               tc
);

  localparam logic [DIGIT_W-1:0] TOP   = DIGIT_W'(LIMIT - 1);
  localparam logic [DIGIT_W:0]   LIM_X = (DIGIT_W + 1)'(LIMIT);

  if (LIMIT < 2 || LIMIT > (1 << DIGIT_W)) begin : g_bad_limit
    $error("lim_digit: LIMIT must lie in 2..2**DIGIT_W");
  end

  logic [DIGIT_W-1:0] nxt;

  always_comb begin
    if (dir) nxt = (q == '0)  ? TOP : q - DIGIT_W'(1);
    else     nxt = (q == TOP) ? '0  : q + DIGIT_W'(1);
  end

  assign tc = dir ? (q == '0) : (q == TOP);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      q <= '0;
    end else if (load) begin
      q <= ({1'b0, load_d} >= LIM_X) ? TOP : load_d;
    end else if (step && cin) begin
      q <= nxt;
    end
  end

endmodule

// File: rtl/lim_chain_counter.sv
// rtl/lim_chain_counter.sv - prescaled cascade of per-digit modulo counters
module lim_chain_counter
  import lim_pkg::*;
#(
  parameter int                        DIGITS   = 4,
  parameter int                        DIGIT_W  = DIGIT_W_DEF,
  parameter logic [DIGITS*DIGIT_W-1:0] LIMITS   = LIMITS_DEF,
  parameter int                        PRESCALE = 100000000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic                      clr,
  input  logic                      dir,
  input  logic                      load,
  input  logic [DIGITS*DIGIT_W-1:0] load_val,
  output logic [DIGITS*DIGIT_W-1:0] count,
  output logic                      tick,
  output logic                      wrap
);

  localparam int            PW    = presc_w(PRESCALE);
  localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);

  if (PRESCALE < 1) begin : g_bad_prescale
    $error("lim_chain_counter: PRESCALE must be at least 1");
  end

  logic [PW-1:0]     psc;
  logic              step;
  logic [DIGITS-1:0] tc;
  logic [DIGITS-1:0] cin;

  assign step = en && (psc == PLAST);

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    // A zero LIMITS field encodes the full 2**DIGIT_W modulus, which cannot fit in DIGIT_W bits.
    localparam logic [DIGIT_W-1:0] FIELD = LIMITS[i*DIGIT_W +: DIGIT_W];
    localparam int                 LIM   = (FIELD == '0) ? (1 << DIGIT_W) : int'(FIELD);

    if (i == 0) begin : g_first
      assign cin[i] = 1'b1;
    end else begin : g_rest
      assign cin[i] = cin[i-1] & tc[i-1];
    end

    lim_digit #(
      .DIGIT_W (DIGIT_W),
      .LIMIT   (LIM)
    ) u_digit (
      .clk    (clk),
      .reset  (reset),
      .clr    (clr),
      .load   (load),
      .load_d (load_val[i*DIGIT_W +: DIGIT_W]),
      .step   (step),
      .dir    (dir),
      .cin    (cin[i]),
      .q      (count[i*DIGIT_W +: DIGIT_W]),
      .tc     (tc[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset || clr || load) begin
      psc  <= '0;
      tick <= 1'b0;
      wrap <= 1'b0;
    end else if (en) begin
      psc  <= step ? '0 : psc + PW'(1);
      tick <= step;
      wrap <= step && (&tc);
    end else begin
      tick <= 1'b0;
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lim_chain_counter.sv
// tb/tb_lim_chain_counter.sv - scoreboard bench for lim_chain_counter
module tb_lim_chain_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] cnt;
    logic       tick;
    logic       wrap;
  } exp_t;

  typedef struct {
    int         k;
    logic [3:0] cnt;
    logic       tick;
    logic       wrap;
  } sexp_t;

  typedef struct {
    bit         rst;
    bit         clr;
    bit         ld;
    logic [7:0] lv;
    bit         en;
    bit         dir;
  } row_t;

  int checks = 0;
  int errors = 0;

  // Two-digit {6,10} instances: prescale 1 (m_) and prescale 4 (p_).
  logic       m_reset, m_en, m_clr, m_dir, m_load;
  logic [7:0] m_lv, m_count;
  logic       m_tick, m_wrap;
  logic       p_reset, p_en, p_clr, p_dir, p_load;
  logic [7:0] p_lv, p_count;
  logic       p_tick, p_wrap;
  // Single-digit instances sharing one set of inputs: LIMIT 2, 11 and 16.
  logic       s_reset, s_en, s_clr, s_dir, s_load;
  logic [3:0] s_lv, c2, c11, c16;
  logic       t2, t11, t16, w2, w11, w16;

  lim_chain_counter #(.DIGITS(2), .DIGIT_W(4), .LIMITS({4'd6, 4'd10}), .PRESCALE(1)) u_main (
    .clk(clk), .reset(m_reset), .en(m_en), .clr(m_clr), .dir(m_dir), .load(m_load),
    .load_val(m_lv), .count(m_count), .tick(m_tick), .wrap(m_wrap));

  lim_chain_counter #(.DIGITS(2), .DIGIT_W(4), .LIMITS({4'd6, 4'd10}), .PRESCALE(4)) u_psc (
    .clk(clk), .reset(p_reset), .en(p_en), .clr(p_clr), .dir(p_dir), .load(p_load),
    .load_val(p_lv), .count(p_count), .tick(p_tick), .wrap(p_wrap));

  lim_chain_counter #(.DIGITS(1), .DIGIT_W(4), .LIMITS(4'd2), .PRESCALE(1)) u_l2 (
    .clk(clk), .reset(s_reset), .en(s_en), .clr(s_clr), .dir(s_dir), .load(s_load),
    .load_val(s_lv), .count(c2), .tick(t2), .wrap(w2));

  lim_chain_counter #(.DIGITS(1), .DIGIT_W(4), .LIMITS(4'd11), .PRESCALE(1)) u_l11 (
    .clk(clk), .reset(s_reset), .en(s_en), .clr(s_clr), .dir(s_dir), .load(s_load),
    .load_val(s_lv), .count(c11), .tick(t11), .wrap(w11));

  lim_chain_counter #(.DIGITS(1), .DIGIT_W(4), .LIMITS(4'd0), .PRESCALE(1)) u_l16 (
    .clk(clk), .reset(s_reset), .en(s_en), .clr(s_clr), .dir(s_dir), .load(s_load),
    .load_val(s_lv), .count(c16), .tick(t16), .wrap(w16));

  exp_t  q_m[$];
  exp_t  q_p[$];
  sexp_t q_s[$];

  logic [7:0] mc[2];
  int         mp[2];

  // Reference model of a {6,10} two-digit chain; k selects which instance's state.
  function automatic exp_t model(input int k, input int presc, input row_t r);
    int   lim[2];
    int   d;
    bit   all;
    bit   term;
    exp_t e;
    lim[0] = 10;
    lim[1] = 6;
    e.tick = 1'b0;
    e.wrap = 1'b0;
    if (r.rst || r.clr) begin
      mc[k] = 8'h00;
      mp[k] = 0;
    end else if (r.ld) begin
      for (int i = 0; i < 2; i++) begin
        d = int'(r.lv[i*4 +: 4]);
        if (d >= lim[i]) d = lim[i] - 1;
        mc[k][i*4 +: 4] = 4'(d);
      end
      mp[k] = 0;
    end else if (r.en) begin
      if (mp[k] == presc - 1) begin
        mp[k]  = 0;
        e.tick = 1'b1;
        all    = 1'b1;
        for (int i = 0; i < 2; i++) begin
          d    = int'(mc[k][i*4 +: 4]);
          term = r.dir ? (d == 0) : (d == lim[i] - 1);
          if (all) d = r.dir ? ((d == 0) ? lim[i] - 1 : d - 1) : ((d == lim[i] - 1) ? 0 : d + 1);
          mc[k][i*4 +: 4] = 4'(d);
          if (!term) all = 1'b0;
        end
        e.wrap = all;
      end else begin
        mp[k] = mp[k] + 1;
      end
    end
    e.cnt = mc[k];
    return e;
  endfunction

  task automatic drive_m(input row_t r);
    m_reset = r.rst; m_clr = r.clr; m_load = r.ld; m_lv = r.lv; m_en = r.en; m_dir = r.dir;
    q_m.push_back(model(0, 1, r));
  endtask

  task automatic drive_p(input row_t r);
    p_reset = r.rst; p_clr = r.clr; p_load = r.ld; p_lv = r.lv; p_en = r.en; p_dir = r.dir;
    q_p.push_back(model(1, 4, r));
  endtask

  function automatic row_t mk(input bit rst, input bit clr, input bit ld, input logic [7:0] lv,
                              input bit en, input bit dir);
    row_t r;
    r.rst = rst; r.clr = clr; r.ld = ld; r.lv = lv; r.en = en; r.dir = dir;
    return r;
  endfunction

  function automatic logic [5:0] s_obs(input int k);
    case (k)
      0:       return {c2, t2, w2};
      1:       return {c11, t11, w11};
      default: return {c16, t16, w16};
    endcase
  endfunction

  task automatic test_reset();
    exp_t e;
    drive_m(mk(1, 0, 1, 8'h33, 1, 0));
    drive_p(mk(1, 1, 0, 8'h00, 1, 1));
    @(posedge clk); #1;
    e = q_m.pop_front();
    checks++;
    if (m_count !== 8'h00 || m_tick !== 1'b0 || m_wrap !== 1'b0 || e.cnt !== 8'h00) begin
      errors++;
      $display("FAIL reset_main: got count=%h tick=%b wrap=%b, want 00/0/0", m_count, m_tick, m_wrap);
    end
    e = q_p.pop_front();
    checks++;
    if (p_count !== e.cnt || p_tick !== e.tick || p_wrap !== e.wrap) begin
      errors++;
      $display("FAIL reset_psc: got count=%h tick=%b wrap=%b, want %h/%b/%b",
               p_count, p_tick, p_wrap, e.cnt, e.tick, e.wrap);
    end
  endtask

  task automatic test_up_wrap();
    exp_t e;
    for (int n = 0; n <= 61; n++) begin
      drive_m(mk(n == 0, 0, 0, 8'h00, 1, 0));
      @(posedge clk); #1;
      e = q_m.pop_front();
      checks++;
      if (m_count !== e.cnt || m_tick !== e.tick || m_wrap !== e.wrap) begin
        errors++;
        $display("FAIL up_count n=%0d: got %h/%b/%b, want %h/%b/%b",
                 n, m_count, m_tick, m_wrap, e.cnt, e.tick, e.wrap);
      end
      if (n == 59 || n == 60 || n == 61) begin
        checks++;
        if (m_count !== ((n == 59) ? 8'h59 : (n == 60) ? 8'h00 : 8'h01) || m_wrap !== (n == 60)) begin
          errors++;
          $display("FAIL up_wrap n=%0d: got count=%h wrap=%b", n, m_count, m_wrap);
        end
      end
    end
  endtask

  task automatic test_down_wrap();
    exp_t e;
    for (int n = 0; n <= 2; n++) begin
      drive_m(mk(0, n == 0, 0, 8'h00, 1, 1));
      @(posedge clk); #1;
      e = q_m.pop_front();
      checks++;
      if (m_count !== e.cnt || m_tick !== e.tick || m_wrap !== e.wrap ||
          (n == 1 && (m_count !== 8'h59 || m_wrap !== 1'b1)) ||
          (n == 2 && (m_count !== 8'h58 || m_wrap !== 1'b0))) begin
        errors++;
        $display("FAIL down_wrap n=%0d: got %h/%b/%b, want %h/%b/%b",
                 n, m_count, m_tick, m_wrap, e.cnt, e.tick, e.wrap);
      end
    end
  endtask

  task automatic test_load();
    exp_t e;
    row_t rows[7];
    rows[0] = mk(0, 0, 1, 8'h7F, 1, 0);
    rows[1] = mk(0, 0, 0, 8'h00, 1, 0);
    rows[2] = mk(0, 0, 0, 8'h00, 1, 0);
    rows[3] = mk(0, 0, 1, 8'h23, 1, 0);
    rows[4] = mk(0, 0, 1, 8'hA5, 0, 1);
    rows[5] = mk(0, 0, 0, 8'h00, 1, 1);
    rows[6] = mk(0, 0, 1, 8'hF9, 1, 1);
    for (int n = 0; n < 7; n++) begin
      drive_m(rows[n]);
      @(posedge clk); #1;
      e = q_m.pop_front();
      checks++;
      if (m_count !== e.cnt || m_tick !== e.tick || m_wrap !== e.wrap ||
          (n == 0 && (m_count !== 8'h59 || m_tick !== 1'b0)) ||
          (n == 3 && (m_count !== 8'h23 || m_tick !== 1'b0))) begin
        errors++;
        $display("FAIL load n=%0d: got %h/%b/%b, want %h/%b/%b",
                 n, m_count, m_tick, m_wrap, e.cnt, e.tick, e.wrap);
      end
    end
  endtask

  task automatic test_priority();
    exp_t e;
    row_t rows[12];
    bit   zero[12];
    rows[0]  = mk(0, 0, 0, 8'h00, 1, 0); zero[0]  = 0;
    rows[1]  = mk(0, 0, 0, 8'h00, 1, 0); zero[1]  = 0;
    rows[2]  = mk(1, 1, 1, 8'h47, 1, 0); zero[2]  = 1;
    rows[3]  = mk(0, 0, 0, 8'h00, 1, 0); zero[3]  = 0;
    rows[4]  = mk(0, 0, 0, 8'h00, 1, 0); zero[4]  = 0;
    rows[5]  = mk(0, 1, 1, 8'h47, 1, 0); zero[5]  = 1;
    rows[6]  = mk(0, 0, 1, 8'h37, 1, 1); zero[6]  = 0;
    rows[7]  = mk(0, 0, 0, 8'h00, 1, 1); zero[7]  = 0;
    rows[8]  = mk(1, 0, 0, 8'h00, 1, 1); zero[8]  = 1;
    rows[9]  = mk(0, 1, 0, 8'h00, 0, 0); zero[9]  = 1;
    rows[10] = mk(0, 0, 1, 8'h42, 0, 0); zero[10] = 0;
    rows[11] = mk(0, 0, 0, 8'h00, 1, 0); zero[11] = 0;
    for (int n = 0; n < 12; n++) begin
      drive_m(rows[n]);
      @(posedge clk); #1;
      e = q_m.pop_front();
      checks++;
      if (m_count !== e.cnt || m_tick !== e.tick || m_wrap !== e.wrap ||
          (zero[n] && (m_count !== 8'h00 || m_tick !== 1'b0 || m_wrap !== 1'b0))) begin
        errors++;
        $display("FAIL priority n=%0d: got %h/%b/%b, want %h/%b/%b",
                 n, m_count, m_tick, m_wrap, e.cnt, e.tick, e.wrap);
      end
    end
  endtask

  task automatic test_dir_hold();
    exp_t       e;
    logic [7:0] held;
    held = m_count;
    for (int n = 0; n < 8; n++) begin
      drive_m(mk(0, 0, 0, 8'h00, n >= 4, n[0]));
      @(posedge clk); #1;
      e = q_m.pop_front();
      checks++;
      if (m_count !== e.cnt || m_tick !== e.tick || m_wrap !== e.wrap ||
          (n < 4 && m_count !== held)) begin
        errors++;
        $display("FAIL dir_hold n=%0d: got %h/%b/%b, want %h/%b/%b",
                 n, m_count, m_tick, m_wrap, e.cnt, e.tick, e.wrap);
      end
    end
  endtask

  task automatic test_random();
    exp_t e;
    row_t r;
    for (int n = 0; n < 300; n++) begin
      r = mk($urandom_range(0, 49) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 14) == 0,
             8'($urandom_range(0, 255)), $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0 ? ~m_dir : m_dir);
      drive_m(r);
      @(posedge clk); #1;
      e = q_m.pop_front();
      checks++;
      if (m_count !== e.cnt || m_tick !== e.tick || m_wrap !== e.wrap) begin
        errors++;
        $display("FAIL random n=%0d: got %h/%b/%b, want %h/%b/%b",
                 n, m_count, m_tick, m_wrap, e.cnt, e.tick, e.wrap);
      end
    end
  endtask

  task automatic test_prescale();
    exp_t e;
    bit   want_tick;
    for (int n = 0; n <= 24; n++) begin
      drive_p(mk(n == 0, 0, 0, 8'h00, !(n >= 10 && n <= 12), 0));
      @(posedge clk); #1;
      e = q_p.pop_front();
      want_tick = (n == 4 || n == 8 || n == 15 || n == 19 || n == 23);
      checks++;
      if (p_count !== e.cnt || p_tick !== e.tick || p_wrap !== e.wrap || p_tick !== want_tick) begin
        errors++;
        $display("FAIL prescale n=%0d: got %h/%b/%b, want %h/%b/%b",
                 n, p_count, p_tick, p_wrap, e.cnt, want_tick, e.wrap);
      end
    end
  endtask

  task automatic test_exhaustive();
    sexp_t      s;
    logic [5:0] o;
    int         lims[3];
    int         x;
    lims[0] = 2; lims[1] = 11; lims[2] = 16;
    for (int v = 0; v < 16; v++) begin
      for (int d = 0; d < 2; d++) begin
        for (int ph = 0; ph < 2; ph++) begin
          s_reset = 1'b0; s_clr = 1'b0; s_en = 1'b1; s_dir = d[0];
          s_load = (ph == 0); s_lv = 4'(v);
          for (int k = 0; k < 3; k++) begin
            x = (v >= lims[k]) ? lims[k] - 1 : v;
            s.k = k;
            if (ph == 0) begin
              s.cnt = 4'(x); s.tick = 1'b0; s.wrap = 1'b0;
            end else begin
              s.cnt  = 4'(d ? ((x == 0) ? lims[k] - 1 : x - 1) : ((x == lims[k] - 1) ? 0 : x + 1));
              s.tick = 1'b1;
              s.wrap = d ? (x == 0) : (x == lims[k] - 1);
            end
            q_s.push_back(s);
          end
          @(posedge clk); #1;
          while (q_s.size() > 0) begin
            s = q_s.pop_front();
            o = s_obs(s.k);
            checks++;
            if (o !== {s.cnt, s.tick, s.wrap}) begin
              errors++;
              $display("FAIL exhaustive lim=%0d v=%0d dir=%0d ph=%0d: got %h/%b/%b, want %h/%b/%b",
                       lims[s.k], v, d, ph, o[5:2], o[1], o[0], s.cnt, s.tick, s.wrap);
            end
          end
        end
      end
    end
  endtask

  initial begin
    m_reset = 1'b1; m_en = 1'b0; m_clr = 1'b0; m_dir = 1'b0; m_load = 1'b0; m_lv = 8'h00;
    p_reset = 1'b1; p_en = 1'b0; p_clr = 1'b0; p_dir = 1'b0; p_load = 1'b0; p_lv = 8'h00;
    s_reset = 1'b1; s_en = 1'b0; s_clr = 1'b0; s_dir = 1'b0; s_load = 1'b0; s_lv = 4'h0;
    mc[0] = 8'h00; mc[1] = 8'h00; mp[0] = 0; mp[1] = 0;
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_load();
    test_priority();
    test_dir_hold();
    test_random();
    test_prescale();
    test_exhaustive();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
